// File: rtl/mips_run_monitor.sv
// Run monitor for the Harvard MIPS CPU benches: watches the CPU status and bus
// strobes and produces one sticky, registered pass/fail verdict with counters.
module mips_run_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned START_TIMEOUT  = 4,
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter logic [31:0] EXPECTED_V0    = 32'h0,
  parameter bit          CHECK_V0       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic [31:0] register_v0,
  input  logic [31:0] instr_address,
  input  logic        instr_read,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  byte_enable,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_code,
  output logic [31:0] cycle_count,
  output logic [31:0] final_v0,
  output logic [31:0] fetch_count
);

  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_NOT_STARTED = 3'd1;
  localparam logic [2:0] FC_TIMEOUT     = 3'd2;
  localparam logic [2:0] FC_BAD_VECTOR  = 3'd3;
  localparam logic [2:0] FC_MISALIGNED  = 3'd4;
  localparam logic [2:0] FC_BUS_CONFL   = 3'd5;
  localparam logic [2:0] FC_BAD_BE      = 3'd6;
  localparam logic [2:0] FC_V0_MISMATCH = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

  state_t      state_q, state_d;
  logic        done_d, pass_d, first_fetch_q, first_fetch_d;
  logic [2:0]  code_d, run_code;
  logic [31:0] cycle_d, v0_d, fetch_d, cyc_inc;

  // The data address is carried for completeness only; nothing checks it.
  logic unused_data_address;
  assign unused_data_address = ^data_address;

  assign cyc_inc = cycle_count + 32'd1;

  // RUN-state error code; lowest-numbered condition wins. Timeout needs
  // active=1, so it can never collide with a completion on the same edge.
  always_comb begin
    run_code = FC_NONE;
    if (cyc_inc == 32'(TIMEOUT_CYCLES) && active)
      run_code = FC_TIMEOUT;
    else if (instr_read && !first_fetch_q && instr_address != RESET_VECTOR)
      run_code = FC_BAD_VECTOR;
    else if (instr_read && instr_address[1:0] != 2'b00)
      run_code = FC_MISALIGNED;
    else if (data_read && data_write)
      run_code = FC_BUS_CONFL;
    else if ((data_read || data_write) && byte_enable == 4'b0000)
      run_code = FC_BAD_BE;
  end

  // Next-state and next-verdict logic; DONE/ERROR hold everything.
  always_comb begin
    state_d       = state_q;
    done_d        = done;
    pass_d        = pass;
    code_d        = fail_code;
    cycle_d       = cycle_count;
    v0_d          = final_v0;
    fetch_d       = fetch_count;
    first_fetch_d = first_fetch_q;
    case (state_q)
      IDLE: begin
        cycle_d = cyc_inc;
        if (active) begin
          state_d = RUN;
        end else if (cyc_inc == 32'(START_TIMEOUT)) begin
          state_d = ERROR;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          code_d  = FC_NOT_STARTED;
          v0_d    = register_v0;
        end
      end
      RUN: begin
        cycle_d = cyc_inc;
        if (instr_read) begin
          fetch_d       = fetch_count + 32'd1;
          first_fetch_d = 1'b1;
        end
        if (run_code != FC_NONE) begin
          state_d = ERROR;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          code_d  = run_code;
          v0_d    = register_v0;
        end else if (!active) begin
          done_d = 1'b1;
          v0_d   = register_v0;
          if (!CHECK_V0 || register_v0 == EXPECTED_V0) begin
            state_d = DONE;
            pass_d  = 1'b1;
            code_d  = FC_NONE;
          end else begin
            state_d = ERROR;
            pass_d  = 1'b0;
            code_d  = FC_V0_MISMATCH;
          end
        end
      end
      default: ;
    endcase
  end

  // State and output registers; synchronous reset aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_code     <= FC_NONE;
      cycle_count   <= '0;
      final_v0      <= '0;
      fetch_count   <= '0;
      first_fetch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done          <= done_d;
      pass          <= pass_d;
      fail_code     <= code_d;
      cycle_count   <= cycle_d;
      final_v0      <= v0_d;
      fetch_count   <= fetch_d;
      first_fetch_q <= first_fetch_d;
    end
  end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: one instance checks v0, a second
// instance on the same inputs has v0 checking disabled.
module tb_mips_run_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic        active, instr_read, data_read, data_write;
  logic [31:0] register_v0, instr_address, data_address;
  logic [3:0]  byte_enable;
  logic        done, pass, done_nc, pass_nc;
  logic [2:0]  fail_code, fail_code_nc;
  logic [31:0] cycle_count, final_v0, fetch_count;
  logic [31:0] cycle_count_nc, final_v0_nc, fetch_count_nc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_run_monitor #(.TIMEOUT_CYCLES(40), .START_TIMEOUT(4),
    .RESET_VECTOR(32'hBFC00000), .EXPECTED_V0(32'h5), .CHECK_V0(1'b1)) dut (
    .clk(clk), .rst(rst), .active(active), .register_v0(register_v0),
    .instr_address(instr_address), .instr_read(instr_read),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .byte_enable(byte_enable), .done(done), .pass(pass), .fail_code(fail_code),
    .cycle_count(cycle_count), .final_v0(final_v0), .fetch_count(fetch_count));

  mips_run_monitor #(.TIMEOUT_CYCLES(40), .START_TIMEOUT(4),
    .RESET_VECTOR(32'hBFC00000), .EXPECTED_V0(32'h5), .CHECK_V0(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .active(active), .register_v0(register_v0),
    .instr_address(instr_address), .instr_read(instr_read),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .byte_enable(byte_enable), .done(done_nc), .pass(pass_nc),
    .fail_code(fail_code_nc), .cycle_count(cycle_count_nc),
    .final_v0(final_v0_nc), .fetch_count(fetch_count_nc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one edge worth of CPU inputs, then clock it.
  task automatic cyc(input logic act, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [3:0] be,
                     input logic [31:0] v0);
    active = act; instr_read = ir; instr_address = ia;
    data_read = dr; data_write = dw; byte_enable = be; register_v0 = v0;
    tick();
  endtask

  task automatic idle_inputs();
    active = 1'b0; instr_read = 1'b0; instr_address = '0; data_address = 32'h1000;
    data_read = 1'b0; data_write = 1'b0; byte_enable = 4'hF; register_v0 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_verdict(input string tag, input logic d, input logic p,
                             input logic [2:0] c, input logic [31:0] cc);
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".pass"}, 32'(pass), 32'(p));
    chk({tag, ".code"}, 32'(fail_code), 32'(c));
    chk({tag, ".cycles"}, cycle_count, cc);
  endtask

  // Active rises on edge 2, fetches BFC00000.. on edges 3..9, active falls
  // on edge 10 with the given v0.
  task automatic normal_run(input logic [31:0] v0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    for (int e = 3; e <= 9; e++)
      cyc(1'b1, 1'b1, 32'hBFC00000 + 32'((e - 3) * 4), 1'b0, e == 5, 4'hF, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, v0);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    // Reset state
    do_reset();
    chk_verdict("reset", 1'b0, 1'b0, 3'd0, 32'd0);
    chk("reset.v0", final_v0, 32'd0);
    chk("reset.fetch", fetch_count, 32'd0);

    // Normal passing run
    normal_run(32'h5);
    chk_verdict("normal", 1'b1, 1'b1, 3'd0, 32'd10);
    chk("normal.v0", final_v0, 32'h5);
    chk("normal.fetch", fetch_count, 32'd7);
    chk("normal_nc.pass", 32'(pass_nc), 32'd1);
    // Absorbing: further edges with garbage inputs change nothing
    cyc(1'b1, 1'b1, 32'h3, 1'b1, 1'b1, 4'h0, 32'h99);
    cyc(1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 4'h0, 32'h99);
    chk_verdict("absorb", 1'b1, 1'b1, 3'd0, 32'd10);
    chk("absorb.v0", final_v0, 32'h5);
    chk("absorb.fetch", fetch_count, 32'd7);

    // v0 mismatch; the unchecked instance still passes
    do_reset();
    normal_run(32'h6);
    chk_verdict("mismatch", 1'b1, 1'b0, 3'd7, 32'd10);
    chk("mismatch.v0", final_v0, 32'h6);
    chk("mismatch_nc.pass", 32'(pass_nc), 32'd1);
    chk("mismatch_nc.code", 32'(fail_code_nc), 32'd0);
    chk("mismatch_nc.v0", final_v0_nc, 32'h6);

    // Run timeout: active never falls
    do_reset();
    for (int e = 1; e <= 39; e++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    chk("tmo.pre_done", 32'(done), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    chk_verdict("tmo", 1'b1, 1'b0, 3'd2, 32'd40);

    // Start timeout: active never rises
    do_reset();
    for (int e = 1; e <= 3; e++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    chk("nostart.pre_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    chk_verdict("nostart", 1'b1, 1'b0, 3'd1, 32'd4);

    // Bad first fetch vector
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    chk_verdict("badvec", 1'b1, 1'b0, 3'd3, 32'd2);
    chk("badvec.fetch", fetch_count, 32'd1);

    // Misaligned later fetch
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    cyc(1'b1, 1'b1, 32'hBFC00000, 1'b0, 1'b0, 4'hF, 32'h0);
    chk("misal.pre_done", 32'(done), 32'd0);
    cyc(1'b1, 1'b1, 32'hBFC00006, 1'b0, 1'b0, 4'hF, 32'h0);
    chk_verdict("misal", 1'b1, 1'b0, 3'd4, 32'd3);
    chk("misal.fetch", fetch_count, 32'd2);

    // Misaligned first fetch: bad vector takes priority
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    cyc(1'b1, 1'b1, 32'h00000002, 1'b0, 1'b0, 4'hF, 32'h0);
    chk("prio34.code", 32'(fail_code), 32'd3);

    // Read and write together
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0);
    chk_verdict("conflict", 1'b1, 1'b0, 3'd5, 32'd2);

    // Write with no byte enables
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0);
    chk_verdict("badbe", 1'b1, 1'b0, 3'd6, 32'd2);

    // Bad byte enable on the completion edge beats completion
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h5);
    chk_verdict("becompl", 1'b1, 1'b0, 3'd6, 32'd2);
    chk("becompl.v0", final_v0, 32'h5);
    chk("becompl_nc.code", 32'(fail_code_nc), 32'd6);

    // Reset mid-run, then a clean run counted from the new reset
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0);
    for (int e = 2; e <= 5; e++)
      cyc(1'b1, 1'b1, 32'hBFC00000 + 32'((e - 2) * 4), 1'b0, 1'b0, 4'hF, 32'h0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 32'hBFC00010, 1'b0, 1'b0, 4'hF, 32'h7);
    rst = 1'b0;
    chk_verdict("midrst", 1'b0, 1'b0, 3'd0, 32'd0);
    chk("midrst.v0", final_v0, 32'd0);
    chk("midrst.fetch", fetch_count, 32'd0);
    idle_inputs();
    normal_run(32'h5);
    chk_verdict("rerun", 1'b1, 1'b1, 3'd0, 32'd10);
    chk("rerun.fetch", fetch_count, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
- Synthesisable-style run monitor that sits directly downstream of mips_cpu_harvard in the CPU test benches.
- Consumes the CPU's status and bus outputs: active, register_v0, and the instruction and data port address/strobe signals.
- Produces a single registered verdict: done, pass, fail_code, cycle count, captured v0 and fetch count.
- Replaces ad-hoc @(negedge active) / $fatal timeout logic, so every bench gets identical pass/fail semantics.

Parameters:
- TIMEOUT_CYCLES, 40: maximum edges allowed in IDLE+RUN before a TIMEOUT error.
- START_TIMEOUT, 4: maximum edges in IDLE waiting for active=1.
- RESET_VECTOR, 32'hBFC00000: required address of the first instruction fetch.
- EXPECTED_V0, 32'h0: expected register_v0 at completion.
- CHECK_V0, 1: 1 = compare v0 against EXPECTED_V0; 0 = any v0 passes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- active  in  1  CPU running flag.
- register_v0  in  32  CPU $v0 debug output.
- instr_address  in  32  CPU instruction fetch address.
- instr_read  in  1  CPU instruction fetch strobe.
- data_address  in  32  CPU data port address (informational only, unchecked).
- data_read  in  1  CPU data read strobe.
- data_write  in  1  CPU data write strobe.
- byte_enable  in  4  CPU data byte enables.
- done  out  1  run finished (completion or error); sticky.
- pass  out  1  valid when done=1; 1 = success.
- fail_code  out  3  0 NONE, 1 NOT_STARTED, 2 TIMEOUT, 3 BAD_VECTOR, 4 MISALIGNED_FETCH, 5 BUS_CONFLICT, 6 BAD_BYTE_ENABLE, 7 V0_MISMATCH.
- cycle_count  out  32  edges spent in IDLE+RUN.
- final_v0  out  32  register_v0 captured at completion.
- fetch_count  out  32  instr_read=1 edges sampled in RUN.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state=IDLE and clears done, pass, fail_code, cycle_count, final_v0, fetch_count and first_fetch_seen.
  - Reset overrides everything; asserting it mid-run aborts the run with no verdict.
- Outputs: all registered; no combinational paths from inputs to outputs.
- cycle_count: +1 on every non-reset edge while state is IDLE or RUN; frozen in DONE/ERROR.
- FSM states: IDLE, RUN, DONE, ERROR.
- IDLE:
  - active=1 -> RUN.
  - Otherwise, if cycle_count+1 == START_TIMEOUT -> ERROR, code 1.
- RUN checks, evaluated on every edge. When several conditions hold at once, the lowest-numbered code wins:
  - First instr_read=1 in RUN with instr_address != RESET_VECTOR -> code 3. first_fetch_seen is set by the first fetch whether it passes or fails.
  - instr_read=1 and instr_address[1:0] != 0 -> code 4.
  - data_read=1 and data_write=1 together -> code 5.
  - (data_read | data_write)=1 and byte_enable == 0 -> code 6.
  - cycle_count+1 == TIMEOUT_CYCLES and active=1 -> code 2.
- Priority between outcomes:
  - Protocol errors (codes 3-6) beat completion on the same edge.
  - Completion (active=0) beats timeout on the same edge.
- Completion: active=0 sampled in RUN with no protocol error:
  - final_v0 <= register_v0 on that edge.
  - If CHECK_V0=0 or register_v0 == EXPECTED_V0: state -> DONE, done=1, pass=1, fail_code=0.
  - Otherwise: state -> ERROR, done=1, pass=0, fail_code=7.
- Entering ERROR: done=1, pass=0, fail_code=code. final_v0 is still captured from register_v0 on that edge.
- fetch_count: +1 per RUN edge with instr_read=1, including the edge that triggers an error.
- DONE/ERROR: absorbing until rst; inputs ignored.
- Latency: verdict visible immediately after the deciding edge.
- Counter widths: 32-bit counters never wrap in practice, since TIMEOUT_CYCLES < 2^32; no saturation logic.

Test Plan:
- Normal run: after reset, active=1 at edge 2; first fetch 32'hBFC00000; active=0 at edge 10 with v0=32'h00000005; EXPECTED_V0=5 -> done=1, pass=1, fail_code=0, final_v0=5, cycle_count=10.
- Mismatch and CHECK_V0 off: same run with v0=32'h00000006 -> fail_code=7, pass=0, final_v0=6. With CHECK_V0=0 -> pass=1.
- Timeouts:
  - active never falls, TIMEOUT_CYCLES=40 -> fail_code=2, cycle_count=40, done=1.
  - active never rises, START_TIMEOUT=4 -> fail_code=1, cycle_count=4.
- Fetch errors:
  - First fetch at 32'h00000000 -> fail_code=3.
  - Later fetch at 32'hBFC00006 -> fail_code=4.
  - Fetch at 32'h00000002 as the first fetch -> fail_code=3 (priority).
- Data port errors:
  - data_read=data_write=1 together -> fail_code=5.
  - data_write=1 with byte_enable=4'b0000 -> fail_code=6.
  - data_write=1 with byte_enable=0 on the same edge active falls -> fail_code=6, not completion.
- Reset mid-run: rst pulse at edge 6 of a run -> all outputs 0, state IDLE. A subsequent clean run passes with cycle_count counted from the new reset.
